// File: rtl/rr_credit_dispatcher_pkg.sv
// Shared types and the round-robin target picker for rr_credit_dispatcher.
// The lane count and credit depth live here so every file agrees on widths.
package rr_credit_dispatcher_pkg;

    localparam int LANES       = 4;
    localparam int PAYLOAD_W   = 8;
    localparam int DEF_CREDITS = 2;
    localparam int CREDIT_MAX  = DEF_CREDITS;
    localparam int SW          = $clog2(LANES);
    localparam int CW          = $clog2(CREDIT_MAX + 1);

    typedef logic [SW-1:0] lane_idx_t;
    typedef logic [CW-1:0] credit_t;

    // Scan from farthest to nearest so the first eligible lane after 'last'
    // (wrapping, with 'last' itself considered final) wins.
    function automatic lane_idx_t next_rr(input lane_idx_t last,
                                          input logic [LANES-1:0] elig);
        lane_idx_t sel;
        lane_idx_t cand;
        sel = last;
        for (int i = LANES; i >= 1; i--) begin
            cand = last + lane_idx_t'(i);
            if (elig[cand]) sel = cand;
        end
        return sel;
    endfunction

endpackage

// File: rtl/rr_credit_dispatcher_counter.sv
// Per-lane saturating up/down credit counter; flags a return into a full lane.
// Reset restores the full credit allowance.
module rr_credit_counter
    import rr_credit_dispatcher_pkg::*;
#(
    parameter int MAX = CREDIT_MAX
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    inc,
    input  logic    dec,
    output credit_t count,
    output logic    overflow
);

    credit_t count_next;

    always_comb begin
        count_next = count;
        overflow   = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (count == credit_t'(MAX)) overflow = 1'b1;
                else count_next = count + credit_t'(1);
            end
            2'b01:   count_next = count - credit_t'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) count <= credit_t'(MAX);
        else       count <= count_next;
    end

endmodule

// File: rtl/rr_credit_dispatcher.sv
// Fans one valid/ready stream out round-robin to credit-flow-controlled lanes.
// Optional dispatch counter and starvation flags behind RR_DISPATCH_CNT_EN.
module rr_credit_dispatcher
    import rr_credit_dispatcher_pkg::*;
#(
    parameter int N       = LANES,
    parameter int W       = PAYLOAD_W,
    parameter int CREDITS = DEF_CREDITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_bits,
    output logic [N-1:0]    out_valid,
    output logic [W-1:0]    out_bits,
    output lane_idx_t       out_sel,
    input  logic [N-1:0]    credit_ret,
    output logic            credit_err
`ifdef RR_DISPATCH_CNT_EN
    ,
    output logic [15:0]     dispatch_cnt,
    output logic [N-1:0]    lane_starved
`endif
);

    credit_t    cred [N];
    logic [N-1:0] elig;
    logic [N-1:0] consume;
    logic [N-1:0] ovf;
    lane_idx_t  last;
    lane_idx_t  target;
    logic       fire;

    // Readiness depends only on registered counts, never on this cycle's inputs.
    assign in_ready = |elig;
    assign target   = next_rr(last, elig);
    assign fire     = in_valid & in_ready;

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign elig[k]    = (cred[k] != '0);
        assign consume[k] = fire && (target == lane_idx_t'(k));

        rr_credit_counter #(
            .MAX(CREDITS)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc     (credit_ret[k]),
            .dec     (consume[k]),
            .count   (cred[k]),
            .overflow(ovf[k])
        );
    end

    // Registered output stage: one-cycle strobe after accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= '0;
            out_bits   <= '0;
            out_sel    <= '0;
            last       <= '0;
            credit_err <= 1'b0;
        end else begin
            out_valid  <= fire ? ({{(N-1){1'b0}}, 1'b1} << target) : '0;
            credit_err <= credit_err | (|ovf);
            if (fire) begin
                out_bits <= in_bits;
                out_sel  <= target;
                last     <= target;
            end
        end
    end

`ifdef RR_DISPATCH_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)     dispatch_cnt <= '0;
        else if (fire) dispatch_cnt <= dispatch_cnt + 16'd1;
    end

    for (genvar k = 0; k < N; k++) begin : g_starved
        assign lane_starved[k] = (cred[k] == '0);
    end
`endif

endmodule
